// File: rtl/sclk_meter_pkg.sv
// Shared constants for the prescaler interface: counter widths and the
// sclk_meter FSM state encoding.
package sclk_meter_pkg;

  localparam int SCLK_WIDTH       = 16;
  localparam int PRESCALE_WIDTH   = 16;
  localparam int PRESCALE_MIN_DIV = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

endpackage

// File: rtl/sclk_meter_sync_edge_det.sv
// Two-flop synchronizer plus history flop for an asynchronous input, with
// enable-gated rise/fall detection (combinational and registered strobes).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic rise_comb,
  output logic fall_comb,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  assign rise_comb = en & s2 & ~s3;
  assign fall_comb = en & ~s2 & s3;

  // The registered strobes line up with the cycle in which the caller acts
  // on the combinational versions, so both views agree on "the edge cycle".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= rise_comb;
      fall <= fall_comb;
    end
  end

endmodule

// File: rtl/sclk_meter.sv
// Measures period and high time of a slow foreign clock in sysclk cycles,
// with rise/fall strobes and a sticky no-edge timeout.
module sclk_meter
  import sclk_meter_pkg::*;
#(
  parameter int          WIDTH   = SCLK_WIDTH,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_mod_en,
  input  logic             i_sclk,
  output logic             o_sclk_rise,
  output logic             o_sclk_fall,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

  logic             rise;
  logic             fall;
  logic [1:0]       state;
  logic [WIDTH-1:0] per_cnt;
  logic             fall_seen;

  sync_edge_det u_sync (
    .clk       (i_sysclk),
    .rst       (i_sysrst),
    .en        (i_mod_en),
    .d         (i_sclk),
    .rise_comb (rise),
    .fall_comb (fall),
    .rise      (o_sclk_rise),
    .fall      (o_sclk_fall)
  );

  // The FSM reacts to the combinational edges so per_cnt reads 1 in the same
  // cycle the registered rise strobe is visible.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state     <= ST_IDLE;
      per_cnt   <= '0;
      fall_seen <= 1'b0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_mod_en) begin
        state     <= ST_IDLE;
        per_cnt   <= '0;
        fall_seen <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            per_cnt   <= '0;
            fall_seen <= 1'b0;
            state     <= ST_ARM;
          end
          ST_ARM: begin
            if (rise) begin
              per_cnt   <= CNT_ONE;
              fall_seen <= 1'b0;
              state     <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              // A rise without a fall in between is a restart, never a result.
              if (fall_seen) begin
                o_period  <= per_cnt;
                o_valid   <= 1'b1;
                o_timeout <= 1'b0;
              end
              per_cnt   <= CNT_ONE;
              fall_seen <= 1'b0;
            end else if (per_cnt == TIMEOUT_CNT) begin
              o_timeout <= 1'b1;
              per_cnt   <= '0;
              fall_seen <= 1'b0;
              state     <= ST_ARM;
            end else begin
              if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_ONE;
              end
              if (fall) begin
                o_high    <= per_cnt;
                fall_seen <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sclk_meter.md
Name: sclk_meter

Overview:
Measures a slow serial clock such as the prescaler's o_sclk, counting the system clock cycles it spans. Reports the period and the high time of that clock, and re-derives one-cycle rise/fall strobes in the i_sysclk domain. Sits on the receive side of the prescaler interface, where it is used for self-check of the loaded scale value and for foreign-clock monitoring.

Parameters:
WIDTH, 16, width of the period and high-time counters and outputs
TIMEOUT, 16'hFFFF, sysclk cycles without a rising edge before o_timeout asserts (must be >= 2, <= 2^WIDTH-1)

Ports:
i_sysclk  in  1  system clock, all logic on its rising edge
i_sysrst  in  1  reset, asynchronous, active-high
i_mod_en  in  1  module enable; low holds the FSM in IDLE
i_sclk  in  1  measured clock, asynchronous to i_sysclk
o_sclk_rise  out  1  one-cycle strobe per synchronized rising edge
o_sclk_fall  out  1  one-cycle strobe per synchronized falling edge
o_period  out  WIDTH  last measured rise-to-rise period, in sysclk cycles
o_high  out  WIDTH  last measured rise-to-fall high time, in sysclk cycles
o_valid  out  1  one-cycle pulse when o_period/o_high update
o_timeout  out  1  sticky level: no rising edge within TIMEOUT cycles

Behaviour:
- Reset (async, active-high): every output is 0, the synchronizer flops are 0, the counters are 0, and the FSM is IDLE. Reset takes effect immediately, including mid-measurement.
- Synchronizer: two flops s1 and s2, plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3. The strobes are registered outputs.
  - Latency: a level change on i_sclk sampled at edge k produces its strobe high in the cycle after edge k+2, i.e. 3 sysclk edges.
  - The strobes are gated by i_mod_en.
- Minimum measurable i_sclk high and low time is 1 sysclk cycle each, so the minimum period is 2.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: entered on reset or whenever i_mod_en=0 (this has priority over all other transitions). Counters are cleared; o_period, o_high and o_timeout hold their values. Goes to ARM when i_mod_en=1.
  - ARM: waits for the first rise. On rise: per_cnt<=1, fall_seen<=0, go to MEASURE. No o_valid is issued from ARM.
  - MEASURE: per_cnt increments each cycle, saturating at 2^WIDTH-1.
    - On fall: o_high<=per_cnt, fall_seen<=1.
    - On rise with fall_seen=1: o_period<=per_cnt, o_valid=1 for one cycle, o_timeout<=0, per_cnt<=1, fall_seen<=0.
    - On rise with fall_seen=0 (cannot occur after synchronization): restart without o_valid.
    - When per_cnt reaches TIMEOUT with no rise: o_timeout<=1, go to ARM. o_period and o_high hold their values.
- Counting convention: per_cnt is 1 in the cycle of the rise strobe. A clock with H cycles high and L cycles low gives o_period=H+L and o_high=H.
- o_valid and o_timeout never assert in the same cycle. o_period and o_high are stable between o_valid pulses.

Decomposition:
- Shared package: WIDTH default and the FSM state encoding (IDLE=2'd0, ARM=2'd1, MEASURE=2'd2), alongside the prescaler's constants.
- One natural sub-module: sync_edge_det (2-flop synchronizer + history flop + rise/fall strobes). It is reusable by the counter top for its external count input.

Test Plan:
- Reset: assert i_sysrst mid-measurement (i_sclk toggling, i_mod_en=1) -> all outputs 0 in the same cycle. After release, the first o_valid appears only at the second rise after ARM.
- Symmetric clock: i_sclk 4 high/4 low, i_mod_en=1 -> o_valid once per 8 cycles with o_period=8, o_high=4. Rise strobe appears 3 edges after the i_sclk transition.
- Duty and minimum: 3 high/7 low -> o_period=10, o_high=3. Then 1 high/1 low -> o_period=2, o_high=1, and every rise/fall is strobed.
- Enable: drop i_mod_en mid-period -> strobes stop and o_period holds. Re-enable -> no o_valid at the first rise, correct o_valid at the second.
- Timeout: TIMEOUT=20, i_sclk held low after a rise -> o_timeout=1 when per_cnt reaches 20, FSM returns to ARM. Resume 5/5 toggling -> o_timeout clears with the next o_valid (o_period=10).
